// File: rtl/icache_dm_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Default geometry: 16 sets, one word per block.
package icache_dm_pkg;

    localparam int ICACHE_NSETS = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_NSETS);
    localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Datapath-side and memory-side bundles of the instruction cache.
// Handshakes: imemREN is answered by ihit in the same cycle; iREN is held with a stable iaddr until a cycle with iwait=0, and iload is taken in that cycle.
interface datapath_cache_if;
    logic        flush;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;

    modport icache (input flush, imemREN, imemaddr, output ihit, imemload);
    modport dp     (output flush, imemREN, imemaddr, input ihit, imemload);
endinterface

interface caches_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport icache (output iREN, iaddr, input iwait, iload);
    modport mem    (input iREN, iaddr, output iwait, iload);
endinterface

// File: rtl/icache_array.sv
// Register-based valid/tag/data storage: one combinational read port,
// one posedge write port, and a flush that clears every valid bit.
module icache_array
    import icache_dm_pkg::*;
#(
    parameter  int NSETS = ICACHE_NSETS,
    localparam int IDX_W = $clog2(NSETS),
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic [IDX_W-1:0] ridx,
    output logic             rvalid,
    output logic [TAG_W-1:0] rtag,
    output logic [31:0]      rdata,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [TAG_W-1:0] wtag,
    input  logic [31:0]      wdata
);

    logic [NSETS-1:0] valid;
    logic [TAG_W-1:0] tags [NSETS];
    logic [31:0]      data [NSETS];

    // Flush has priority: a line written in the flush cycle is left invalid.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (we) begin
            valid[widx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (we) begin
            tags[widx] <= wtag;
            data[widx] <= wdata;
        end
    end

    assign rvalid = valid[ridx];
    assign rtag   = tags[ridx];
    assign rdata  = data[ridx];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: zero-latency hits, single-word fill on a miss,
// hit/miss performance counters.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter  int NSETS = ICACHE_NSETS,
    localparam int IDX_W = $clog2(NSETS),
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic              CLK,
    input  logic              nRST,
    datapath_cache_if.icache  dcif,
    caches_if.icache          cif,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt,
    output icache_state_t     state_dbg
);

    icache_state_t    state, next_state;
    logic [31:0]      miss_addr;
    logic [31:0]      req_addr;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic             rvalid;
    logic [TAG_W-1:0] rtag;
    logic [31:0]      rdata;
    logic             fill_we;
    logic             miss;
    logic             ihit;
    logic [31:0]      imemload;
    logic             iren;
    logic [31:0]      iaddr;

    assign req_addr = word_align(dcif.imemaddr);
    assign req_tag  = req_addr[31:IDX_W+2];
    assign req_idx  = req_addr[IDX_W+1:2];

    icache_array #(.NSETS(NSETS)) u_array (
        .CLK    (CLK),
        .nRST   (nRST),
        .flush  (dcif.flush),
        .ridx   (req_idx),
        .rvalid (rvalid),
        .rtag   (rtag),
        .rdata  (rdata),
        .we     (fill_we),
        .widx   (miss_addr[IDX_W+1:2]),
        .wtag   (miss_addr[31:IDX_W+2]),
        .wdata  (cif.iload)
    );

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = '0;
        iren       = 1'b0;
        iaddr      = '0;
        fill_we    = 1'b0;
        miss       = 1'b0;
        case (state)
            IDLE: begin
                if (dcif.imemREN) begin
                    if (rvalid && (rtag == req_tag)) begin
                        ihit     = 1'b1;
                        imemload = rdata;
                    end else begin
                        miss       = 1'b1;
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                // Datapath inputs are ignored here; the fill always finishes for miss_addr.
                iren  = 1'b1;
                iaddr = miss_addr;
                if (!cif.iwait) begin
                    fill_we    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_addr <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            state <= next_state;
            if (miss) begin
                miss_addr <= req_addr;
                miss_cnt  <= miss_cnt + 32'd1;
            end
            if (ihit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
        end
    end

    assign dcif.ihit     = ihit;
    assign dcif.imemload = imemload;
    assign cif.iREN      = iren;
    assign cif.iaddr     = iaddr;
    assign state_dbg     = state;

endmodule
